// File: rtl/wb_retire_queue_pkg.sv
// Shared definitions for the write-back retire queue: MEM lane layout,
// register-file write-port layout and the queued entry format.
package wb_retire_queue_pkg;

  // MEM lane: {lane_v, c0_rdata, mfc0, gr_we, dest, result, pc}
  localparam int LANE_W          = 107;
  localparam int LANE_PC_LSB     = 0;
  localparam int LANE_RESULT_LSB = 32;
  localparam int LANE_DEST_LSB   = 64;
  localparam int LANE_GRWE_LSB   = 69;
  localparam int LANE_MFC0_BIT   = 73;
  localparam int LANE_C0_LSB     = 74;
  localparam int LANE_V_BIT      = 106;

  // RF write port: {we, waddr, wdata}
  localparam int RF_PORT_W       = 41;
  localparam int RF_WDATA_LSB    = 0;
  localparam int RF_WADDR_LSB    = 32;
  localparam int RF_WE_LSB       = 37;

  typedef struct packed {
    logic [3:0]  gr_we;
    logic [4:0]  dest;
    logic [31:0] wdata;
    logic [31:0] pc;
  } wb_entry_t;

  // Build a queue entry from a lane's payload (lane_v excluded); the
  // CP0 read value replaces the ALU result for mfc0.
  function automatic wb_entry_t lane_to_entry(input logic [LANE_V_BIT-1:0] lane);
    wb_entry_t e;
    e.gr_we = lane[LANE_GRWE_LSB +: 4];
    e.dest  = lane[LANE_DEST_LSB +: 5];
    e.wdata = lane[LANE_MFC0_BIT] ? lane[LANE_C0_LSB +: 32] : lane[LANE_RESULT_LSB +: 32];
    e.pc    = lane[LANE_PC_LSB +: 32];
    return e;
  endfunction

endpackage

// File: rtl/wb_retire_queue_port_merge.sv
// wb_port_merge: masks write enables across the ports retiring in one cycle.
// A port writing r0 is dropped, and an older port is dropped when a younger
// active port writes the same register, so only the newest value lands.
module wb_port_merge
  import wb_retire_queue_pkg::*;
#(
  parameter int WPORTS = 2
) (
  input  logic [WPORTS-1:0]           active,
  input  logic [WPORTS-1:0][3:0]      we_in,
  input  logic [WPORTS-1:0][4:0]      waddr_in,
  input  logic [WPORTS-1:0][31:0]     wdata_in,
  output logic [WPORTS*RF_PORT_W-1:0] rf_bus
);

  logic [WPORTS-1:0][3:0] we_m;

  // Per-port enable after r0 and same-destination masking
  always_comb begin
    we_m = '0;
    for (int p = 0; p < WPORTS; p++) begin
      if (active[p] && waddr_in[p] != 5'd0) we_m[p] = we_in[p];
      for (int q = p + 1; q < WPORTS; q++) begin
        if (active[q] && we_in[q] != 4'd0 && waddr_in[q] == waddr_in[p]) we_m[p] = 4'd0;
      end
    end
  end

  // Pack ports onto the RF bus, port 0 in the LSBs
  always_comb begin
    rf_bus = '0;
    for (int p = 0; p < WPORTS; p++) begin
      rf_bus[p*RF_PORT_W + RF_WE_LSB    +: 4]  = we_m[p];
      rf_bus[p*RF_PORT_W + RF_WADDR_LSB +: 5]  = waddr_in[p];
      rf_bus[p*RF_PORT_W + RF_WDATA_LSB +: 32] = wdata_in[p];
    end
  end

endmodule

// File: rtl/wb_retire_queue.sv
// Write-back retire queue: compacts valid MEM lanes into a circular queue and
// retires from the head onto the register-file write ports every cycle.
// Optional build macro WB_TRACE_EN: retire one entry per cycle and drive the
// debug_wb_* golden-trace port from it; otherwise debug_wb_* are tied to 0.
module wb_retire_queue
  import wb_retire_queue_pkg::*;
#(
  parameter int LANES  = 2,
  parameter int DEPTH  = 4,
  parameter int WPORTS = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ms_to_ws_valid,
  input  logic [LANES*LANE_W-1:0]     ms_to_ws_bus,
  output logic                        ws_allowin,
  output logic [WPORTS*RF_PORT_W-1:0] ws_to_rf_bus,
  output logic [31:0]                 ws_pending,
  output logic [31:0]                 debug_wb_pc,
  output logic [3:0]                  debug_wb_rf_wen,
  output logic [4:0]                  debug_wb_rf_wnum,
  output logic [31:0]                 debug_wb_rf_wdata
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
`ifdef WB_TRACE_EN
  localparam int RMAX = 1;
`else
  localparam int RMAX = WPORTS;
`endif

  wb_entry_t                q_data [DEPTH];
  logic [DEPTH-1:0]         q_valid;
  logic [PW-1:0]            head;
  logic [PW-1:0]            tail;
  logic [CW-1:0]            count;

  logic                     accept;
  logic [LANES-1:0]         lane_take;
  logic [LANES-1:0][PW-1:0] lane_slot;
  logic [CW-1:0]            enq_n;

  logic [WPORTS-1:0]        ret_active;
  logic [WPORTS-1:0][PW-1:0] ret_idx;
  logic [WPORTS-1:0][3:0]   ret_we;
  logic [WPORTS-1:0][4:0]   ret_dest;
  logic [WPORTS-1:0][31:0]  ret_wdata;
  logic [CW-1:0]            ret_n;

  // Room for a whole group is judged on the registered count only, so the
  // handshake never depends on this cycle's retirement.
  assign ws_allowin = (CW'(DEPTH) - count) >= CW'(LANES);
  assign accept     = ms_to_ws_valid && ws_allowin;

  // Compact valid lanes onto consecutive slots starting at the tail
  always_comb begin
    enq_n     = '0;
    lane_take = '0;
    lane_slot = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_take[i] = accept && ms_to_ws_bus[i*LANE_W + LANE_V_BIT];
      lane_slot[i] = tail + PW'(enq_n);
      if (lane_take[i]) enq_n = enq_n + CW'(1);
    end
  end

  // Select up to RMAX head entries; nothing retires while reset is held so
  // in-flight entries are dropped without touching the RF.
  always_comb begin
    ret_n      = '0;
    ret_active = '0;
    for (int p = 0; p < WPORTS; p++) begin
      ret_idx[p]   = head + PW'(p);
      ret_we[p]    = q_data[ret_idx[p]].gr_we;
      ret_dest[p]  = q_data[ret_idx[p]].dest;
      ret_wdata[p] = q_data[ret_idx[p]].wdata;
      if (p < RMAX && !reset && CW'(p) < count) begin
        ret_active[p] = 1'b1;
        ret_n         = ret_n + CW'(1);
      end
    end
  end

  // Queue control: pointers, count and per-entry valid bits
  always_ff @(posedge clk) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      q_valid <= '0;
    end else begin
      for (int p = 0; p < WPORTS; p++) begin
        if (ret_active[p]) q_valid[ret_idx[p]] <= 1'b0;
      end
      for (int i = 0; i < LANES; i++) begin
        if (lane_take[i]) q_valid[lane_slot[i]] <= 1'b1;
      end
      head  <= head + PW'(ret_n);
      tail  <= tail + PW'(enq_n);
      count <= count + enq_n - ret_n;
    end
  end

  // Entry payload; qualified by q_valid so it needs no reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (lane_take[i]) q_data[lane_slot[i]] <= lane_to_entry(ms_to_ws_bus[i*LANE_W +: LANE_V_BIT]);
    end
  end

  // Scoreboard of registers still owed a write by queued entries
  always_comb begin
    ws_pending = '0;
    for (int e = 0; e < DEPTH; e++) begin
      if (q_valid[e] && q_data[e].gr_we != 4'd0) ws_pending[q_data[e].dest] = 1'b1;
    end
  end

  wb_port_merge #(
    .WPORTS   (WPORTS)
  ) u_port_merge (
    .active   (ret_active),
    .we_in    (ret_we),
    .waddr_in (ret_dest),
    .wdata_in (ret_wdata),
    .rf_bus   (ws_to_rf_bus)
  );

`ifdef WB_TRACE_EN
  assign debug_wb_pc       = ret_active[0] ? q_data[head].pc : 32'd0;
  assign debug_wb_rf_wen   = ws_to_rf_bus[RF_WE_LSB +: 4];
  assign debug_wb_rf_wnum  = ret_active[0] ? ret_dest[0] : 5'd0;
  assign debug_wb_rf_wdata = ret_active[0] ? ret_wdata[0] : 32'd0;
`else
  // pc is only observed by the trace port
  logic pc_unused;
  assign pc_unused         = ^q_data[head].pc;
  assign debug_wb_pc       = 32'd0;
  assign debug_wb_rf_wen   = 4'd0;
  assign debug_wb_rf_wnum  = 5'd0;
  assign debug_wb_rf_wdata = 32'd0;
`endif

endmodule

// File: tb/tb_wb_retire_queue.sv
// Directed testbench for wb_retire_queue (LANES=2, DEPTH=4, WPORTS=2).
module tb_wb_retire_queue;

  logic         clk = 1'b0;
  logic         reset;
  logic         ms_to_ws_valid;
  logic [213:0] ms_to_ws_bus;
  logic         ws_allowin;
  logic [81:0]  ws_to_rf_bus;
  logic [31:0]  ws_pending;
  logic [31:0]  debug_wb_pc;
  logic [3:0]   debug_wb_rf_wen;
  logic [4:0]   debug_wb_rf_wnum;
  logic [31:0]  debug_wb_rf_wdata;

  int checks = 0;
  int errors = 0;

  wb_retire_queue #(.LANES(2), .DEPTH(4), .WPORTS(2)) dut (
    .clk               (clk),
    .reset             (reset),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .ws_allowin        (ws_allowin),
    .ws_to_rf_bus      (ws_to_rf_bus),
    .ws_pending        (ws_pending),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
  );

  always #5 clk = ~clk;

  function automatic logic [106:0] mk_lane(input logic v, input logic [31:0] c0, input logic mfc0,
                                           input logic [3:0] we, input logic [4:0] dest,
                                           input logic [31:0] res, input logic [31:0] pc);
    return {v, c0, mfc0, we, dest, res, pc};
  endfunction

  function automatic logic [3:0] we_of(input int p);
    return ws_to_rf_bus[p*41 + 37 +: 4];
  endfunction

  function automatic logic [4:0] addr_of(input int p);
    return ws_to_rf_bus[p*41 + 32 +: 5];
  endfunction

  function automatic logic [31:0] data_of(input int p);
    return ws_to_rf_bus[p*41 +: 32];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset          = 1'b1;
    ms_to_ws_valid = 1'b0;
    ms_to_ws_bus   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_allowin", ws_allowin, 1);
    chk("rst_pending", ws_pending, 0);
    chk("rst_we0", we_of(0), 0);
    chk("rst_we1", we_of(1), 0);
    chk("rst_count", dut.count, 0);
    chk("rst_trace_wen", debug_wb_rf_wen, 0);
    reset = 1'b0;

`ifndef WB_TRACE_EN
    // Two-lane group, dests 3 and 4
    ms_to_ws_valid = 1'b1;
    ms_to_ws_bus   = {mk_lane(1, 0, 0, 4'hF, 5'd4, 32'h44, 32'h104),
                      mk_lane(1, 0, 0, 4'hF, 5'd3, 32'h33, 32'h100)};
    chk("grp_allowin", ws_allowin, 1);
    step();
    ms_to_ws_valid = 1'b0;
    chk("grp_we0", we_of(0), 4'hF);
    chk("grp_addr0", addr_of(0), 3);
    chk("grp_data0", data_of(0), 32'h33);
    chk("grp_we1", we_of(1), 4'hF);
    chk("grp_addr1", addr_of(1), 4);
    chk("grp_data1", data_of(1), 32'h44);
    chk("grp_pending", ws_pending, 32'h18);
    chk("grp_count", dut.count, 2);
    step();
    chk("grp_pending_clr", ws_pending, 0);
    chk("grp_idle_we0", we_of(0), 0);
    chk("grp_idle_we1", we_of(1), 0);
    chk("grp_count_clr", dut.count, 0);

    // Same destination in one retire cycle: only the younger write lands
    ms_to_ws_valid = 1'b1;
    ms_to_ws_bus   = {mk_lane(1, 0, 0, 4'hF, 5'd5, 32'hBBBB, 32'h10C),
                      mk_lane(1, 0, 0, 4'hF, 5'd5, 32'hAAAA, 32'h108)};
    step();
    ms_to_ws_valid = 1'b0;
    chk("dup_we0", we_of(0), 0);
    chk("dup_we1", we_of(1), 4'hF);
    chk("dup_addr1", addr_of(1), 5);
    chk("dup_data1", data_of(1), 32'hBBBB);
    chk("dup_pending", ws_pending, 32'h20);
    step();
    chk("dup_count_clr", dut.count, 0);

    // Lane 0 masked off: single entry lands on port 0
    ms_to_ws_valid = 1'b1;
    ms_to_ws_bus   = {mk_lane(1, 0, 0, 4'hF, 5'd7, 32'h77, 32'h200),
                      mk_lane(0, 0, 0, 4'hF, 5'd6, 32'h66, 32'h1FC)};
    step();
    ms_to_ws_valid = 1'b0;
    chk("mask_count", dut.count, 1);
    chk("mask_we0", we_of(0), 4'hF);
    chk("mask_addr0", addr_of(0), 7);
    chk("mask_data0", data_of(0), 32'h77);
    chk("mask_we1", we_of(1), 0);
    chk("mask_pending", ws_pending, 32'h80);
    step();
    chk("mask_count_clr", dut.count, 0);

    // mfc0 picks c0_rdata; dest 0 never writes
    ms_to_ws_valid = 1'b1;
    ms_to_ws_bus   = {mk_lane(1, 0, 0, 4'hF, 5'd0, 32'h55, 32'h208),
                      mk_lane(1, 32'h1234, 1, 4'hF, 5'd8, 32'h9999, 32'h204)};
    step();
    ms_to_ws_valid = 1'b0;
    chk("mfc0_we0", we_of(0), 4'hF);
    chk("mfc0_addr0", addr_of(0), 8);
    chk("mfc0_data0", data_of(0), 32'h1234);
    chk("r0_we1", we_of(1), 0);
    step();

    // Reset with entries queued and a group in flight
    ms_to_ws_valid = 1'b1;
    ms_to_ws_bus   = {mk_lane(1, 0, 0, 4'hF, 5'd21, 32'h21, 32'h304),
                      mk_lane(1, 0, 0, 4'hF, 5'd20, 32'h20, 32'h300)};
    step();
    ms_to_ws_bus   = {mk_lane(1, 0, 0, 4'hF, 5'd23, 32'h23, 32'h30C),
                      mk_lane(1, 0, 0, 4'hF, 5'd22, 32'h22, 32'h308)};
    chk("pre_rst_count", dut.count, 2);
    reset = 1'b1;
    #1;
    chk("in_rst_we0", we_of(0), 0);
    chk("in_rst_we1", we_of(1), 0);
    step();
    reset          = 1'b0;
    ms_to_ws_valid = 1'b0;
    chk("post_rst_count", dut.count, 0);
    chk("post_rst_we0", we_of(0), 0);
    chk("post_rst_we1", we_of(1), 0);
    chk("post_rst_pending", ws_pending, 0);
    chk("post_rst_allowin", ws_allowin, 1);
    step();
    chk("post_rst2_we0", we_of(0), 0);
    chk("post_rst2_we1", we_of(1), 0);
    chk("notrace_pc", debug_wb_pc, 0);
    chk("notrace_wen", debug_wb_rf_wen, 0);
`else
    // Three back-to-back full groups, one retire per cycle
    ms_to_ws_valid = 1'b1;
    ms_to_ws_bus   = {mk_lane(1, 0, 0, 4'hF, 5'd11, 32'h11, 32'h304),
                      mk_lane(1, 0, 0, 4'hF, 5'd10, 32'h10, 32'h300)};
    chk("tr_allow_c0", ws_allowin, 1);
    step();
    ms_to_ws_bus   = {mk_lane(1, 0, 0, 4'hF, 5'd13, 32'h13, 32'h30C),
                      mk_lane(1, 0, 0, 4'hF, 5'd12, 32'h12, 32'h308)};
    chk("tr_allow_c1", ws_allowin, 1);
    chk("tr_pc_c1", debug_wb_pc, 32'h300);
    chk("tr_wen_c1", debug_wb_rf_wen, 4'hF);
    chk("tr_wnum_c1", debug_wb_rf_wnum, 10);
    chk("tr_we1_c1", we_of(1), 0);
    step();
    ms_to_ws_bus   = {mk_lane(1, 0, 0, 4'hF, 5'd15, 32'h15, 32'h314),
                      mk_lane(1, 0, 0, 4'hF, 5'd14, 32'h14, 32'h310)};
    chk("tr_allow_c2", ws_allowin, 0);
    chk("tr_pc_c2", debug_wb_pc, 32'h304);
    chk("tr_wen_c2", debug_wb_rf_wen, 4'hF);
    step();
    chk("tr_allow_c3", ws_allowin, 1);
    chk("tr_pc_c3", debug_wb_pc, 32'h308);
    chk("tr_wen_c3", debug_wb_rf_wen, 4'hF);
    step();
    ms_to_ws_valid = 1'b0;
    chk("tr_count_c4", dut.count, 3);
    chk("tr_pc_c4", debug_wb_pc, 32'h30C);
    chk("tr_wen_c4", debug_wb_rf_wen, 4'hF);
    step();
    chk("tr_pc_c5", debug_wb_pc, 32'h310);
    chk("tr_wen_c5", debug_wb_rf_wen, 4'hF);
    step();
    chk("tr_pc_c6", debug_wb_pc, 32'h314);
    chk("tr_wdata_c6", debug_wb_rf_wdata, 32'h15);
    step();
    chk("tr_wen_c7", debug_wb_rf_wen, 0);
    chk("tr_count_c7", dut.count, 0);

    // Reset with three queued entries
    ms_to_ws_valid = 1'b1;
    ms_to_ws_bus   = {mk_lane(1, 0, 0, 4'hF, 5'd21, 32'h21, 32'h404),
                      mk_lane(1, 0, 0, 4'hF, 5'd20, 32'h20, 32'h400)};
    step();
    ms_to_ws_bus   = {mk_lane(1, 0, 0, 4'hF, 5'd23, 32'h23, 32'h40C),
                      mk_lane(1, 0, 0, 4'hF, 5'd22, 32'h22, 32'h408)};
    step();
    ms_to_ws_valid = 1'b0;
    chk("tr_pre_rst_count", dut.count, 3);
    reset = 1'b1;
    #1;
    chk("tr_in_rst_wen", debug_wb_rf_wen, 0);
    chk("tr_in_rst_we0", we_of(0), 0);
    step();
    reset = 1'b0;
    chk("tr_post_rst_count", dut.count, 0);
    chk("tr_post_rst_wen", debug_wb_rf_wen, 0);
    chk("tr_post_rst_pending", ws_pending, 0);
    step();
    chk("tr_post_rst2_we0", we_of(0), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_retire_queue.md
WB_RETIRE_QUEUE -- requirements
Module: wb_retire_queue

Interface
REQ-001 SHALL have parameter LANES, default 2, meaning the number of instruction lanes arriving from MEM per cycle (1..4).
REQ-002 SHALL have parameter DEPTH, default 4, meaning the retire-queue entry count (power of two, >= LANES).
REQ-003 SHALL have parameter WPORTS, default 2, meaning the number of register-file write ports (1..LANES).
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port ms_to_ws_valid, input, 1 bit: the MEM stage offers a lane group.
REQ-007 SHALL have port ms_to_ws_bus, input, LANES*107 bits: per-lane {lane_v, c0_rdata[31:0], mfc0, gr_we[3:0], dest[4:0], result[31:0], pc[31:0]}, with lane 0 in the LSBs and oldest.
REQ-008 SHALL have port ws_allowin, output, 1 bit: the group is accepted this cycle.
REQ-009 SHALL have port ws_to_rf_bus, output, WPORTS*41 bits: per-port {we[3:0], waddr[4:0], wdata[31:0]}, with port 0 oldest.
REQ-010 SHALL have port ws_pending, output, 32 bits: bit r set when any queued entry has gr_we!=0 and dest==r.
REQ-011 SHALL have ports debug_wb_pc (output, 32 bits), debug_wb_rf_wen (output, 4 bits), debug_wb_rf_wnum (output, 5 bits) and debug_wb_rf_wdata (output, 32 bits), forming the trace interface.

Function
REQ-012 SHALL drive ws_allowin = (free entries >= LANES), combinationally from the registered count only.
REQ-013 SHALL, when ms_to_ws_valid && ws_allowin, enqueue every lane with lane_v=1 in ascending lane order, skipping lanes with lane_v=0, with no gaps in the queue.
REQ-014 SHALL compute wdata at enqueue as mfc0 ? c0_rdata : result, storing {gr_we, dest, wdata, pc} per entry.
REQ-015 SHALL retire up to R entries per cycle from the head, in program order, where R = WPORTS (or 1 when trace is enabled, see REQ-024).
REQ-016 SHALL present each retiring entry on consecutive write ports starting at port 0, leaving unused ports at we=0.
REQ-017 SHALL, when two retiring entries in the same cycle target the same nonzero dest with we!=0, force the older port's we to 0.
REQ-018 SHALL force we to 0 for any entry with dest==0.
REQ-019 SHALL have a latency from acceptance to the earliest RF write of one cycle; an entry written in cycle N is absent from ws_pending in cycle N+1.
REQ-020 SHALL perform enqueue and retire in the same cycle, with the count updated by (enq - ret) and pointers wrapping modulo DEPTH.
REQ-021 SHALL make retirement unconditional: the RF never stalls the block.
REQ-022 SHALL set ws_pending from the registered queue state only, with no combinational path from ms_to_ws_bus.

Reset
REQ-023 SHALL, on reset, clear the count, head and tail pointers, all per-entry valid bits, ws_to_rf_bus we fields, ws_pending and debug_wb_rf_wen to 0, drive ws_allowin to 1 in the following cycle, and discard all in-flight entries without performing RF writes.

Configuration
REQ-024 SHALL, with WB_TRACE_EN defined, retire at most one entry per cycle and drive the debug_* ports from that entry (wen = masked we, zero when nothing retires), so that the golden-trace comparison sees every instruction in order.
REQ-025 SHALL, without WB_TRACE_EN, retire up to WPORTS entries per cycle and tie all debug_* outputs to 0.

Structure
REQ-026 SHALL place the lane field widths (107), the per-lane field offsets and the RF port width (41) in the shared mycpu package/header.
REQ-027 SHALL use exactly one sub-module, wb_port_merge, which performs the same-dest masking of REQ-017 and REQ-018 across the retiring ports.

Verification
REQ-028 SHALL verify the following scenario: after reset, LANES=2, offer {pc 0x100 dest 3, pc 0x104 dest 4} -> next cycle port0 writes r3 and port1 writes r4, and ws_pending goes 0x18 -> 0.
REQ-029 SHALL verify the following scenario: same-cycle retirement of dest 5 (0xAAAA) and dest 5 (0xBBBB) -> port0 we=0, port1 writes 0xBBBB to r5.
REQ-030 SHALL verify the following scenario: WB_TRACE_EN, DEPTH=4, three back-to-back full groups -> ws_allowin drops to 0 on the 2nd cycle, and the trace shows 6 pcs in order, one per cycle.
REQ-031 SHALL verify the following scenario: lane mask {lane_v0=0, lane_v1=1}, pc 0x200 -> a single entry is enqueued, the write appears on port 0, and the queue count is 1.
REQ-032 SHALL verify the following scenario: mfc0=1, c0_rdata=0x1234, result=0x9999 -> wdata=0x1234; and dest=0 with gr_we=0xF -> we=0.
REQ-033 SHALL verify the following scenario: reset asserted with 3 queued entries -> no RF writes in the reset cycle or after it, and count=0.
